// File: rtl/image_downscale_avg.sv
// ---------------------------------------------------------------------------
// image_downscale_avg
//
// Box-filter downscaler. Reads a SRC_W x SRC_H greyscale frame from SDRAM in
// raster order, one read outstanding at a time, and sums each BW x BH block
// into one of DST_W column accumulators (BW = SRC_W/DST_W, BH = SRC_H/DST_H).
// At the end of each block-row the averages are moved into a one-row output
// buffer, which an independent sender streams to the UART byte by byte. This
// lets the reads for the next block-row overlap the sending of the last one.
//
// Optional build macro:
//   IMG_DS_ROUND_EN  defined   -> average rounds half up (saturating)
//                    undefined -> average truncates
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle start request, accepted only in IDLE or DONE
//   rd_req    out  one-cycle SDRAM read request
//   rd_addr   out  SDRAM word address, valid while rd_req is high
//   rd_valid  in   read data strobe (only honoured while waiting for data)
//   rd_data   in   pixel returned by SDRAM
//   tx_data   out  byte to UART, held from tx_trmt until tx_done
//   tx_trmt   out  one-cycle transmit strobe
//   tx_done   in   one-cycle pulse when the UART has sent the byte
//   busy      out  high from accepted start until done
//   done      out  level, set after the last byte of a frame is sent
// ---------------------------------------------------------------------------
module image_downscale_avg #(
  parameter int          SRC_W     = 640,
  parameter int          SRC_H     = 480,
  parameter int          DST_W     = 32,
  parameter int          DST_H     = 32,
  parameter int          PIX_W     = 8,
  parameter int          ADDR_W    = 23,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  tx_data,
  output logic              tx_trmt,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  localparam int BW    = SRC_W / DST_W;
  localparam int BH    = SRC_H / DST_H;
  localparam int NPIX  = BW * BH;
  localparam int ACC_W = PIX_W + $clog2(NPIX);
  localparam int XI_W  = (BW > 1) ? $clog2(BW) : 1;
  localparam int YI_W  = (BH > 1) ? $clog2(BH) : 1;
  localparam int BC_W  = (DST_W > 1) ? $clog2(DST_W) : 1;
  localparam int BY_W  = $clog2(DST_H + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_DATA, S_ROW_END, S_STALL, S_FLUSH, S_DONE
  } state_t;

  state_t state, state_nxt;

  // Position inside the frame: pixel within block (xi), block column (bc),
  // line within block-row (yi) and block-row index (by). rd_addr itself is
  // the running raster address, so no multiply is needed for it.
  logic [XI_W-1:0] xi;
  logic [YI_W-1:0] yi;
  logic [BC_W-1:0] bc;
  logic [BY_W-1:0] by;

  logic [ACC_W-1:0] acc [DST_W];
  logic [PIX_W-1:0] ob  [DST_W];
  logic             ob_full;
  logic             in_flight;
  logic [BC_W-1:0]  send_idx;

  // Box average of one accumulator; the divisor is a constant.
  function automatic logic [PIX_W-1:0] avg(input logic [ACC_W-1:0] a);
`ifdef IMG_DS_ROUND_EN
    logic [ACC_W:0] s;
    logic [ACC_W:0] q;
    s = {1'b0, a} + (ACC_W+1)'(NPIX / 2);
    q = s / (ACC_W+1)'(NPIX);
    if (q > (ACC_W+1)'((1 << PIX_W) - 1)) return '1;
    return PIX_W'(q);
`else
    logic [ACC_W-1:0] q;
    q = a / ACC_W'(NPIX);
    return PIX_W'(q);
`endif
  endfunction

  logic start_ok, pix_ok, last_col, row_last, last_tx, ob_free, write_ob;

  assign start_ok = start && (state == S_IDLE || state == S_DONE);
  assign pix_ok   = (state == S_WAIT_DATA) && rd_valid;
  assign last_col = (xi == XI_W'(BW - 1)) && (bc == BC_W'(DST_W - 1));
  assign row_last = last_col && (yi == YI_W'(BH - 1));
  assign last_tx  = in_flight && tx_done && (send_idx == BC_W'(DST_W - 1));
  // The buffer counts as free in the very cycle its last byte completes, so
  // a block-row ending at that moment is written at once rather than stalling.
  assign ob_free  = !ob_full || last_tx;
  assign write_ob = (state == S_ROW_END) && ob_free;

  assign rd_req = (state == S_REQ);
  assign busy   = (state != S_IDLE) && (state != S_DONE);
  assign done   = (state == S_DONE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_REQ;
      S_REQ:          state_nxt = S_WAIT_DATA;
      S_WAIT_DATA:    if (rd_valid) state_nxt = row_last ? S_ROW_END : S_REQ;
      S_ROW_END: begin
        if (ob_free) state_nxt = (by < BY_W'(DST_H - 1)) ? S_REQ : S_FLUSH;
        else         state_nxt = S_STALL;
      end
      S_STALL:        if (!ob_full) state_nxt = S_ROW_END;
      S_FLUSH:        if (!ob_full && !in_flight) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- read position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xi      <= '0;
      yi      <= '0;
      bc      <= '0;
      by      <= '0;
      rd_addr <= ADDR_W'(BASE_ADDR);
    end else if (start_ok) begin
      xi      <= '0;
      yi      <= '0;
      bc      <= '0;
      by      <= '0;
      rd_addr <= ADDR_W'(BASE_ADDR);
    end else begin
      if (pix_ok) begin
        rd_addr <= rd_addr + ADDR_W'(1);
        if (xi == XI_W'(BW - 1)) begin
          xi <= '0;
          if (bc == BC_W'(DST_W - 1)) begin
            bc <= '0;
            yi <= (yi == YI_W'(BH - 1)) ? '0 : yi + YI_W'(1);
          end else begin
            bc <= bc + BC_W'(1);
          end
        end else begin
          xi <= xi + XI_W'(1);
        end
      end
      if (write_ob) by <= by + BY_W'(1);
    end
  end

  // ------------------------------------------------------- accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DST_W; i++) acc[i] <= '0;
    end else if (start_ok || write_ob) begin
      for (int i = 0; i < DST_W; i++) acc[i] <= '0;
    end else if (pix_ok) begin
      acc[bc] <= acc[bc] + ACC_W'(rd_data);
    end
  end

  // ------------------------------------------------------- output buffer
  // NOTE: the buffer payload has no reset; ob_full guards every read of it,
  // so resetting the storage would only cost routing.
  always_ff @(posedge clk) begin
    if (write_ob) begin
      for (int i = 0; i < DST_W; i++) ob[i] <= avg(acc[i]);
    end
  end

  // ------------------------------------------------------------- sender
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_full   <= 1'b0;
      in_flight <= 1'b0;
      send_idx  <= '0;
      tx_data   <= '0;
      tx_trmt   <= 1'b0;
    end else begin
      tx_trmt <= 1'b0;
      if (ob_full && !in_flight) begin
        tx_data   <= ob[send_idx];
        tx_trmt   <= 1'b1;
        in_flight <= 1'b1;
      end
      if (in_flight && tx_done) begin
        in_flight <= 1'b0;
        if (send_idx == BC_W'(DST_W - 1)) begin
          send_idx <= '0;
          ob_full  <= 1'b0;
        end else begin
          send_idx <= send_idx + BC_W'(1);
        end
      end
      // A new row landing in the same cycle the old one drains keeps it full.
      if (write_ob) ob_full <= 1'b1;
    end
  end

endmodule

// File: doc/image_downscale_avg.md
Name: image_downscale_avg

Overview:
Parametrised box-filter downscaler. Reads a SRC_W x SRC_H 8-bit greyscale frame from SDRAM in raster order and averages each BW x BH block, where BW = SRC_W/DST_W and BH = SRC_H/DST_H. Streams the DST_W x DST_H result byte-by-byte to the UART transmitter.
- Uses DST_W column accumulators plus a one-row output buffer, so reading the next block-row overlaps sending the previous one.
- Re-armable: a new frame can be started after each completion.

Parameters:
SRC_W, 640, source width in pixels; must be a multiple of DST_W
SRC_H, 480, source height in lines; must be a multiple of DST_H
DST_W, 32, output width
DST_H, 32, output height
PIX_W, 8, pixel and output byte width
ADDR_W, 23, SDRAM word address width
BASE_ADDR, 0, frame base address in SDRAM

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle start request; ignored unless in IDLE or DONE
rd_req  out  1  one-cycle read request
rd_addr  out  ADDR_W  read address; valid while rd_req is high
rd_valid  in  1  read data strobe, arriving ≥1 cycle after rd_req
rd_data  in  PIX_W  pixel returned by SDRAM
tx_data  out  PIX_W  byte to UART; held stable from tx_trmt until tx_done
tx_trmt  out  1  one-cycle transmit strobe
tx_done  in  1  one-cycle pulse from UART when the byte has been sent
busy  out  1  high from accepted start until done is set
done  out  1  level; set when the last byte's tx_done is seen, cleared on the next accepted start

Behaviour:
- Reset: rd_req=0, rd_addr=BASE_ADDR, tx_data=0, tx_trmt=0, busy=0, done=0. All counters, accumulators and valid flags are cleared. FSM goes to IDLE.
- Reset asserted mid-frame aborts immediately. No further rd_req or tx_trmt is issued.
- Read FSM states: IDLE, REQ, WAIT_DATA, ROW_END, STALL, FLUSH, DONE.
- IDLE/DONE, start=1:
  - clear counters x, y, block-row index by, and all accumulators;
  - clear done; set busy;
  - go to REQ.
- REQ:
  - rd_req=1 for one cycle, rd_addr = BASE_ADDR + y*SRC_W + x;
  - go to WAIT_DATA.
  - Exactly one read is outstanding at a time.
- WAIT_DATA, rd_valid=1:
  - acc[x/BW] += rd_data (zero-extended). Accumulator width = PIX_W + clog2(BW*BH).
  - Advance x; on x wrap, advance y.
  - If the pixel completes the last line of a block-row (y%BH==BH-1 and x==SRC_W-1), go to ROW_END; otherwise go to REQ.
  - rd_valid outside WAIT_DATA is ignored.
- ROW_END:
  - If the output buffer is empty:
    - write ob[i] = acc[i] / (BW*BH) for all i, as a constant divide;
    - clear acc; mark the buffer full with DST_W entries;
    - go to REQ if by < DST_H-1, else FLUSH; increment by.
  - If the buffer is still full, go to STALL.
  - STALL returns to ROW_END the cycle after the buffer becomes empty.
- FLUSH: wait until the buffer is empty and no byte is in flight, then go to DONE. This sets done=1 and busy=0.
- Sender, independent of the read FSM:
  - When the buffer is full and no byte is in flight: drive tx_data = ob[send_idx], pulse tx_trmt for one cycle, set in_flight.
  - On tx_done: clear in_flight and increment send_idx. When send_idx reaches DST_W, mark the buffer empty and reset send_idx to 0.
  - tx_done while not in flight is ignored.
- Ordering: output bytes are sent row-major (row 0 col 0 first). Total DST_W*DST_H bytes per frame, each exactly once.
- Simultaneous events:
  - Buffer empty and ROW_END in the same cycle: the write wins and the buffer becomes full. The sender starts next cycle.
  - start while busy: ignored.
- Minimum latency from rd_valid to the next rd_req is 1 cycle (WAIT_DATA→REQ).

Optional Feature:
IMG_DS_ROUND_EN:
- Defined: average = (acc + (BW*BH)/2) / (BW*BH), i.e. round half up. The result saturates at 2^PIX_W-1 (unreachable in practice, kept for safety).
- Undefined: average = acc / (BW*BH), truncating.
- The accumulator width is identical in both builds.

Test Plan:
All scenarios use SRC_W=8, SRC_H=4, DST_W=2, DST_H=2 (BW=4, BH=2, 8 pixels/block) with a behavioural SDRAM model of 3-cycle latency.
1. Constant frame: every pixel 100, start pulse -> 4 tx_trmt with tx_data=100 each; done=1, busy=0 afterward; exactly 32 rd_req at addresses 0..31.
2. Block-distinct frame: blocks filled with 10/20/30/40 (raster block order) -> bytes sent 10,20,30,40 in that order.
3. Rounding: one block with pixels summing to 12, rest 0 -> first byte 1 with IMG_DS_ROUND_EN undefined, 2 with it defined.
4. Backpressure: tx_done delayed 200 cycles per byte -> reads stall in STALL after the second block-row; no rd_req issued while stalled; all 4 bytes are correct; no byte is sent twice.
5. Re-arm and ignore: start pulsed mid-frame has no effect; start after done clears done, and a second frame with pixels 50 yields four bytes of 50.
6. Reset mid-frame: rst_n low during the 10th read -> all outputs return to reset values at once; a subsequent start produces a correct full frame.
